// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder data-memory target.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Byte-enabled RAM: synchronous write, combinational read, contents not reset.
module mem_resp_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256,
  localparam int unsigned IW    = idx_width(Depth),
  localparam int unsigned Lanes = Width / BYTE_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [Lanes-1:0] be,
  input  logic [IW-1:0]    addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (be[i]) mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Latency-accurate valid/ready data-memory responder, one request in flight.
// Optional misaligned-access error reporting via MEM_RESP_ALIGN_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 256,
  parameter int unsigned Latency = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [Width-1:0] req_wdata,
  input  logic [3:0]       req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Width-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int unsigned IW  = idx_width(Depth);
  localparam logic [3:0]  LAT = 4'(Latency);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [Width-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accept;
  logic             misaligned;
  logic             mem_we;
  logic [IW-1:0]    widx;
  logic [Width-1:0] mem_rdata;

  assign widx = req_addr[IW+1:2];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:IW+2];
  assign misaligned       = (req_addr[1:0] != 2'b00);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:IW+2], req_addr[1:0]};
  assign misaligned       = 1'b0;
`endif

  assign accept = (state_q == IDLE) && req_valid;
  assign mem_we = accept && req_we && !misaligned;

  mem_resp_array #(
    .Width (Width),
    .Depth (Depth)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (req_be),
    .addr  (widx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // WAIT spans Latency+1 edges so rsp_valid rises after accept edge + 1 + Latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LAT == 4'd0) begin
            state_d = RESP;
          end else begin
            cnt_d   = LAT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      rdata_d = (req_we || misaligned) ? '0 : mem_rdata;
      err_d   = misaligned;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (Latency=2 and Latency=0 instances).
module tb_mem_responder;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  int checks   = 0;
  int failures = 0;

  mem_responder #(.Width(32), .Depth(256), .Latency(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.Width(32), .Depth(256), .Latency(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on the Latency=2 instance, optionally stalling rsp_ready.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
    end
    check({tag, "_lat"}, lat, LAT + 1);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_done_valid"}, {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] exp_val;
  logic        exp_misalign_err;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst0_rsp_valid", {31'b0, z_rsp_valid}, 32'd0);
    rst = 1'b1;

    xact("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
    xact("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    xact("st_lane0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 32'h0, 1'b0);
    xact("ld_lane0", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA, 1'b0);
    xact("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, 1'b0);
    xact("ld_stall", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEAA, 1'b0);
    xact("ld_wrap", 1'b0, 32'h410, 32'h0, 4'h0, 0, 32'hDEADBEAA, 1'b0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    exp_misalign_err = 1'b1;
    exp_val = 32'hDEADBEAA;
`else
    exp_misalign_err = 1'b0;
    exp_val = 32'h11223344;
`endif
    xact("st_misal", 1'b1, 32'h13, 32'h11223344, 4'hF, 0, 32'h0, exp_misalign_err);
    xact("ld_after_misal", 1'b0, 32'h10, 32'h0, 4'h0, 0, exp_val, 1'b0);

    // Reset while the store sits in WAIT; the write is already committed.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    xact("ld_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0);

    // Latency=0 instance: seed word 0, then back-to-back loads through the 0x400 alias.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'h12345678;
    z_req_be = 4'hF; z_rsp_ready = 1'b1;
    @(negedge clk);
    check("z_st_valid", {31'b0, z_rsp_valid}, 32'd1);
    check("z_st_rdata", z_rsp_rdata, 32'd0);
    z_req_valid = 1'b0;
    @(negedge clk);
    check("z_st_done", {31'b0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h400; z_req_be = 4'h0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("z_b2b_ready", {31'b0, z_req_ready}, {31'b0, (i % 2) == 0});
      check("z_b2b_valid", {31'b0, z_rsp_valid}, {31'b0, (i % 2) == 1});
      if ((i % 2) == 1) check("z_b2b_rdata", z_rsp_rdata, 32'h12345678);
    end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
